// File: rtl/mem_bus_ctrl.sv
// Bus interface unit between the CPU core and a 32K x 8 memory array.
// Sequences setup/strobe/turnaround phases and owns the shared tristate data bus.
module mem_bus_ctrl #(
  parameter int SETUP_CYCLES  = 1,
  parameter int ACCESS_CYCLES = 2,
  parameter int PROTECT_ROM   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [14:0] mem_addr,
  inout  wire  [7:0]  mem_data,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic        mem_rom_ram
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_TURN   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [2:0] SETUP_LD  = 3'(SETUP_CYCLES);
  localparam logic [2:0] ACCESS_LD = 3'(ACCESS_CYCLES);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_we;
  logic [7:0]  r_wdata;
  logic        r_drive;
  logic        r_wr_en;
  logic        r_rd_en;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [7:0]  r_rdata;
  logic        r_busy;
  logic [14:0] r_addr;
  logic        r_rom_ram;

  logic        w_accept;
  logic        w_reject;

  assign req_ready = (r_state == S_IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;
  // Writes into the ROM half are refused before any bus activity happens.
  assign w_reject  = req_we && !req_addr[15] && (PROTECT_ROM != 0);

  assign mem_data    = r_drive ? r_wdata : 8'hzz;
  assign mem_wr_en   = r_wr_en;
  assign mem_rd_en   = r_rd_en;
  assign mem_addr    = r_addr;
  assign mem_rom_ram = r_rom_ram;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_err     = r_rsp_err;
  assign rsp_rdata   = r_rdata;
  assign busy        = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_we        <= 1'b0;
      r_wdata     <= 8'h00;
      r_drive     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= 8'h00;
      r_busy      <= 1'b0;
      r_addr      <= 15'd0;
      r_rom_ram   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we      <= req_we;
            r_wdata   <= req_wdata;
            r_addr    <= req_addr[14:0];
            r_rom_ram <= req_addr[15];
            r_busy    <= 1'b1;
            if (w_reject) begin
              r_state     <= S_ERR;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state <= S_SETUP;
              r_cnt   <= SETUP_LD;
              r_drive <= req_we;
            end
          end
        end
        S_SETUP: begin
          if (r_cnt == 3'd1) begin
            r_state <= S_STROBE;
            r_cnt   <= ACCESS_LD;
            r_wr_en <= r_we;
            r_rd_en <= !r_we;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_STROBE: begin
          if (r_cnt == 3'd1) begin
            r_state     <= S_TURN;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rsp_valid <= 1'b1;
            if (!r_we) r_rdata <= mem_data;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_TURN: begin
          // Write data is held through this cycle, then the bus is released.
          r_state <= S_IDLE;
          r_drive <= 1'b0;
          r_busy  <= 1'b0;
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_drive <= 1'b0;
          r_wr_en <= 1'b0;
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
